// File: rtl/image_rgb_ycbcr_conv_if.sv
// Video bus for the RGB-to-YCbCr converter: input timing/pixels, mode request,
// and the delayed timing, converted pixels and status coming back.
interface image_rgb_ycbcr_conv_if #(
    parameter int unsigned DW = 8
);
    logic [1:0]    mode;
    logic          per_frame_vsync;
    logic          per_frame_href;
    logic          per_frame_hsync;
    logic          per_frame_clken;
    logic [DW-1:0] per_img_red;
    logic [DW-1:0] per_img_green;
    logic [DW-1:0] per_img_blue;
    logic          post_frame_vsync;
    logic          post_frame_href;
    logic          post_frame_hsync;
    logic          post_frame_clken;
    logic [DW-1:0] post_img_Y;
    logic [DW-1:0] post_img_Cb;
    logic [DW-1:0] post_img_Cr;
    logic          post_sat;
    logic [1:0]    mode_active;

    modport master (
        output mode, per_frame_vsync, per_frame_href, per_frame_hsync, per_frame_clken,
        output per_img_red, per_img_green, per_img_blue,
        input  post_frame_vsync, post_frame_href, post_frame_hsync, post_frame_clken,
        input  post_img_Y, post_img_Cb, post_img_Cr, post_sat, mode_active
    );

    modport slave (
        input  mode, per_frame_vsync, per_frame_href, per_frame_hsync, per_frame_clken,
        input  per_img_red, per_img_green, per_img_blue,
        output post_frame_vsync, post_frame_href, post_frame_hsync, post_frame_clken,
        output post_img_Y, post_img_Cb, post_img_Cr, post_sat, mode_active
    );
endinterface

// File: rtl/image_rgb_ycbcr_conv.sv
// Three-stage pipelined RGB-to-YCbCr 4:4:4 converter with frame-synchronous
// mode selection, half-up rounding, saturation and aligned sync delay.
module image_rgb_ycbcr_conv #(
    parameter int unsigned DW       = 8,
    parameter int unsigned MODE_RST = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    image_rgb_ycbcr_conv_if.slave bus
);
    localparam int unsigned AW = DW + 11;
    typedef logic signed [AW-1:0] acc_t;

    localparam acc_t       OFF_H     = acc_t'(2 ** (DW + 7));  // 2^(DW-1) scaled by 256
    localparam acc_t       OFF_L     = acc_t'(2 ** (DW + 4));  // 16*2^(DW-8) scaled by 256
    localparam acc_t       RND       = acc_t'(128);
    localparam acc_t       MAX_V     = acc_t'(2 ** DW - 1);
    localparam logic [1:0] MODE_INIT = 2'(MODE_RST);

    logic                vsync_prev_q;
    logic [1:0]          mode_active_q;
    logic signed [9:0]   coef [3][3];
    acc_t                comp [3];
    acc_t                prod_q [3][3];
    logic [1:0]          tag1_q;
    acc_t                off [3];
    acc_t                sum_q [3];
    logic [1:0]          tag2_q;
    acc_t                shifted [3];
    logic [DW-1:0]       res_d [3];
    logic                sat_d;
    logic [DW-1:0]       res_q [3];
    logic                sat_q;
    logic [3:0]          sync_q [3];

    // Latch the requested mode only on a vsync rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_q  <= 1'b0;
            mode_active_q <= MODE_INIT;
        end else begin
            vsync_prev_q <= bus.per_frame_vsync;
            if (bus.per_frame_vsync && !vsync_prev_q) begin
                mode_active_q <= bus.mode;
            end
        end
    end

    // Coefficient matrix for the active mode; bypass is identity x256 with no offset.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 3; i++) begin
                coef[c][i] = '0;
            end
        end
        unique case (mode_active_q)
            2'd0: begin
                coef[0][0] =  10'sd77;  coef[0][1] =  10'sd150; coef[0][2] =  10'sd29;
                coef[1][0] = -10'sd43;  coef[1][1] = -10'sd85;  coef[1][2] =  10'sd128;
                coef[2][0] =  10'sd128; coef[2][1] = -10'sd107; coef[2][2] = -10'sd21;
            end
            2'd1: begin
                coef[0][0] =  10'sd54;  coef[0][1] =  10'sd183; coef[0][2] =  10'sd19;
                coef[1][0] = -10'sd29;  coef[1][1] = -10'sd99;  coef[1][2] =  10'sd128;
                coef[2][0] =  10'sd128; coef[2][1] = -10'sd116; coef[2][2] = -10'sd12;
            end
            2'd2: begin
                coef[0][0] =  10'sd66;  coef[0][1] =  10'sd129; coef[0][2] =  10'sd25;
                coef[1][0] = -10'sd38;  coef[1][1] = -10'sd74;  coef[1][2] =  10'sd112;
                coef[2][0] =  10'sd112; coef[2][1] = -10'sd94;  coef[2][2] = -10'sd18;
            end
            2'd3: begin
                coef[0][0] = 10'sd256;
                coef[1][1] = 10'sd256;
                coef[2][2] = 10'sd256;
            end
        endcase
    end

    assign comp[0] = acc_t'(bus.per_img_red);
    assign comp[1] = acc_t'(bus.per_img_green);
    assign comp[2] = acc_t'(bus.per_img_blue);

    // Stage 1: nine products plus the mode tag of this pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < 3; i++) begin
                    prod_q[c][i] <= '0;
                end
            end
            tag1_q <= 2'd0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < 3; i++) begin
                    prod_q[c][i] <= acc_t'(coef[c][i]) * comp[i];
                end
            end
            tag1_q <= mode_active_q;
        end
    end

    // Offsets follow the pixel's own mode tag, not the current mode_active.
    always_comb begin
        off[0] = (tag1_q == 2'd2) ? OFF_L : '0;
        off[1] = (tag1_q == 2'd3) ? '0 : OFF_H;
        off[2] = (tag1_q == 2'd3) ? '0 : OFF_H;
    end

    // Stage 2: row sums with offset and rounding constant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                sum_q[c] <= '0;
            end
            tag2_q <= 2'd0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                sum_q[c] <= prod_q[c][0] + prod_q[c][1] + prod_q[c][2] + off[c] + RND;
            end
            tag2_q <= tag1_q;
        end
    end

    // Scale back down and clamp each channel to [0, 2^DW-1].
    always_comb begin
        sat_d = 1'b0;
        for (int c = 0; c < 3; c++) begin
            shifted[c] = sum_q[c] >>> 8;
            res_d[c]   = shifted[c][DW-1:0];
            if (shifted[c][AW-1]) begin
                res_d[c] = '0;
                sat_d    = 1'b1;
            end else if (shifted[c] > MAX_V) begin
                res_d[c] = '1;
                sat_d    = 1'b1;
            end
        end
        if (tag2_q == 2'd3) begin
            sat_d = 1'b0;
        end
    end

    // Stage 3: saturated results and the per-pixel clip flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                res_q[c] <= '0;
            end
            sat_q <= 1'b0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                res_q[c] <= res_d[c];
            end
            sat_q <= sat_d;
        end
    end

    // Sync signals ride a 3-deep shift register to stay aligned with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= {bus.per_frame_vsync, bus.per_frame_href,
                          bus.per_frame_hsync, bus.per_frame_clken};
            sync_q[1] <= sync_q[0];
            sync_q[2] <= sync_q[1];
        end
    end

    assign bus.post_frame_vsync = sync_q[2][3];
    assign bus.post_frame_href  = sync_q[2][2];
    assign bus.post_frame_hsync = sync_q[2][1];
    assign bus.post_frame_clken = sync_q[2][0];
    assign bus.post_img_Y       = sync_q[2][2] ? res_q[0] : '0;
    assign bus.post_img_Cb      = sync_q[2][2] ? res_q[1] : '0;
    assign bus.post_img_Cr      = sync_q[2][2] ? res_q[2] : '0;
    assign bus.post_sat         = sync_q[2][2] & sat_q;
    assign bus.mode_active      = mode_active_q;
endmodule

// File: tb/tb_image_rgb_ycbcr_conv.sv
// Directed bench for image_rgb_ycbcr_conv at DW=8 and DW=10.
module tb_image_rgb_ycbcr_conv;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    image_rgb_ycbcr_conv_if #(.DW(8))  bus8 ();
    image_rgb_ycbcr_conv_if #(.DW(10)) bus10 ();

    image_rgb_ycbcr_conv #(.DW(8), .MODE_RST(0)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    image_rgb_ycbcr_conv #(.DW(10), .MODE_RST(2)) u_dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus10)
    );

    typedef struct {
        logic       vs;
        logic       href;
        logic [1:0] mode;
        logic [7:0] r, g, b;
        logic [7:0] ey, ecb, ecr;
        logic       es;
        logic [1:0] ema;
    } vec_t;

    task automatic idle_all();
        bus8.mode = 2'd0;  bus8.per_frame_vsync = 1'b0;  bus8.per_frame_href = 1'b0;
        bus8.per_frame_hsync = 1'b0;  bus8.per_frame_clken = 1'b0;
        bus8.per_img_red = '0;  bus8.per_img_green = '0;  bus8.per_img_blue = '0;
        bus10.mode = 2'd0; bus10.per_frame_vsync = 1'b0; bus10.per_frame_href = 1'b0;
        bus10.per_frame_hsync = 1'b0; bus10.per_frame_clken = 1'b0;
        bus10.per_img_red = '0; bus10.per_img_green = '0; bus10.per_img_blue = '0;
    endtask

    // Hold one pixel on the DW=8 bus and check it three clocks later.
    task automatic pix8(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] ey, input logic [7:0] ecb, input logic [7:0] ecr,
                        input logic es, input string name);
        @(negedge clk);
        bus8.per_frame_vsync = 1'b0;
        bus8.per_frame_href  = 1'b1;
        bus8.per_img_red = r; bus8.per_img_green = g; bus8.per_img_blue = b;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus8.post_img_Y !== ey)
            $display("FAIL %s Y: got %0d expected %0d", name, bus8.post_img_Y, ey);
        else n_pass++;
        n_checks++;
        if (bus8.post_img_Cb !== ecb)
            $display("FAIL %s Cb: got %0d expected %0d", name, bus8.post_img_Cb, ecb);
        else n_pass++;
        n_checks++;
        if (bus8.post_img_Cr !== ecr)
            $display("FAIL %s Cr: got %0d expected %0d", name, bus8.post_img_Cr, ecr);
        else n_pass++;
        n_checks++;
        if (bus8.post_sat !== es)
            $display("FAIL %s sat: got %0b expected %0b", name, bus8.post_sat, es);
        else n_pass++;
    endtask

    task automatic pix10(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                         input logic href, input logic [9:0] ey, input logic [9:0] ecb,
                         input logic [9:0] ecr, input logic es, input string name);
        @(negedge clk);
        bus10.per_frame_vsync = 1'b0;
        bus10.per_frame_href  = href;
        bus10.per_img_red = r; bus10.per_img_green = g; bus10.per_img_blue = b;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus10.post_img_Y !== ey)
            $display("FAIL %s Y: got %0d expected %0d", name, bus10.post_img_Y, ey);
        else n_pass++;
        n_checks++;
        if (bus10.post_img_Cb !== ecb)
            $display("FAIL %s Cb: got %0d expected %0d", name, bus10.post_img_Cb, ecb);
        else n_pass++;
        n_checks++;
        if (bus10.post_img_Cr !== ecr)
            $display("FAIL %s Cr: got %0d expected %0d", name, bus10.post_img_Cr, ecr);
        else n_pass++;
        n_checks++;
        if (bus10.post_sat !== es)
            $display("FAIL %s sat: got %0b expected %0b", name, bus10.post_sat, es);
        else n_pass++;
    endtask

    // One-cycle vsync pulse on the DW=8 bus requesting mode m, then check the latch.
    task automatic vsync8(input logic [1:0] m);
        @(negedge clk);
        bus8.mode = m; bus8.per_frame_vsync = 1'b1; bus8.per_frame_href = 1'b0;
        @(negedge clk);
        bus8.per_frame_vsync = 1'b0;
        n_checks++;
        if (bus8.mode_active !== m)
            $display("FAIL vsync8 mode_active: got %0d expected %0d", bus8.mode_active, m);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus8.post_frame_vsync, bus8.post_frame_href, bus8.post_frame_hsync,
             bus8.post_frame_clken, bus8.post_sat, bus8.post_img_Y, bus8.post_img_Cb,
             bus8.post_img_Cr} !== 29'd0)
            $display("FAIL reset dut8 outputs: got Y=%0d Cb=%0d Cr=%0d expected all 0",
                     bus8.post_img_Y, bus8.post_img_Cb, bus8.post_img_Cr);
        else n_pass++;
        n_checks++;
        if (bus8.mode_active !== 2'd0)
            $display("FAIL reset dut8 mode_active: got %0d expected 0", bus8.mode_active);
        else n_pass++;
        n_checks++;
        if (bus10.mode_active !== 2'd2)
            $display("FAIL reset dut10 mode_active: got %0d expected 2", bus10.mode_active);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_vsync();
        // Mode request without a vsync edge must be ignored.
        @(negedge clk);
        bus10.mode = 2'd1;
        @(negedge clk);
        n_checks++;
        if (bus10.mode_active !== 2'd2)
            $display("FAIL no_edge mode_active: got %0d expected 2", bus10.mode_active);
        else n_pass++;
        bus10.mode = 2'd0; bus10.per_frame_vsync = 1'b1;
        @(negedge clk);
        bus10.per_frame_vsync = 1'b0;
        n_checks++;
        if (bus10.mode_active !== 2'd0)
            $display("FAIL first_vsync mode_active: got %0d expected 0", bus10.mode_active);
        else n_pass++;
    endtask

    task automatic test_mode0();
        pix8(8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 1'b0, "m0_white");
        pix8(8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128, 1'b0, "m0_black");
        pix8(8'd0,   8'd0,   8'd255, 8'd29,  8'd255, 8'd107, 1'b1, "m0_blue");
        pix8(8'd255, 8'd0,   8'd0,   8'd77,  8'd85,  8'd255, 1'b1, "m0_red");
        pix8(8'd100, 8'd150, 8'd200, 8'd141, 8'd161, 8'd99,  1'b0, "m0_mix");
    endtask

    task automatic test_mode1();
        vsync8(2'd1);
        pix8(8'd0, 8'd255, 8'd0, 8'd182, 8'd29, 8'd12, 1'b0, "m1_green");
    endtask

    task automatic test_mode2();
        vsync8(2'd2);
        pix8(8'd255, 8'd255, 8'd255, 8'd235, 8'd128, 8'd128, 1'b0, "m2_white");
        pix8(8'd0,   8'd0,   8'd0,   8'd16,  8'd128, 8'd128, 1'b0, "m2_black");
        pix8(8'd255, 8'd0,   8'd0,   8'd82,  8'd90,  8'd240, 1'b0, "m2_red");
        vsync8(2'd0);
    endtask

    // Streamed pixels, one per clock, across a mid-frame mode request and vsync rise.
    task automatic test_back_to_back();
        vec_t tbl [7];
        tbl[0] = '{1'b0, 1'b1, 2'd3, 8'd255, 8'd0,   8'd0,   8'd77,  8'd85,  8'd255, 1'b1, 2'd0};
        tbl[1] = '{1'b0, 1'b1, 2'd3, 8'd0,   8'd0,   8'd255, 8'd29,  8'd255, 8'd107, 1'b1, 2'd0};
        tbl[2] = '{1'b1, 1'b1, 2'd3, 8'd255, 8'd0,   8'd0,   8'd77,  8'd85,  8'd255, 1'b1, 2'd3};
        tbl[3] = '{1'b1, 1'b1, 2'd0, 8'd255, 8'd0,   8'd0,   8'd255, 8'd0,   8'd0,   1'b0, 2'd3};
        tbl[4] = '{1'b1, 1'b0, 2'd0, 8'd255, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 2'd3};
        tbl[5] = '{1'b0, 1'b1, 2'd0, 8'd10,  8'd200, 8'd37,  8'd10,  8'd200, 8'd37,  1'b0, 2'd3};
        tbl[6] = '{1'b0, 1'b1, 2'd0, 8'd100, 8'd150, 8'd200, 8'd100, 8'd150, 8'd200, 1'b0, 2'd3};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                n_checks++;
                if ({bus8.post_img_Y, bus8.post_img_Cb, bus8.post_img_Cr, bus8.post_sat} !==
                    {tbl[c-3].ey, tbl[c-3].ecb, tbl[c-3].ecr, tbl[c-3].es})
                    $display("FAIL b2b pixel %0d: got Y=%0d Cb=%0d Cr=%0d sat=%0b expected Y=%0d Cb=%0d Cr=%0d sat=%0b",
                             c - 3, bus8.post_img_Y, bus8.post_img_Cb, bus8.post_img_Cr,
                             bus8.post_sat, tbl[c-3].ey, tbl[c-3].ecb, tbl[c-3].ecr,
                             tbl[c-3].es);
                else n_pass++;
                n_checks++;
                if ({bus8.post_frame_vsync, bus8.post_frame_href} !== {tbl[c-3].vs, tbl[c-3].href})
                    $display("FAIL b2b sync %0d: got vs=%0b href=%0b expected vs=%0b href=%0b",
                             c - 3, bus8.post_frame_vsync, bus8.post_frame_href,
                             tbl[c-3].vs, tbl[c-3].href);
                else n_pass++;
            end
            if (c >= 1 && c <= 7) begin
                n_checks++;
                if (bus8.mode_active !== tbl[c-1].ema)
                    $display("FAIL b2b mode_active after %0d: got %0d expected %0d",
                             c - 1, bus8.mode_active, tbl[c-1].ema);
                else n_pass++;
            end
            if (c < 7) begin
                bus8.per_frame_vsync = tbl[c].vs;
                bus8.per_frame_href  = tbl[c].href;
                bus8.mode            = tbl[c].mode;
                bus8.per_img_red = tbl[c].r; bus8.per_img_green = tbl[c].g;
                bus8.per_img_blue = tbl[c].b;
            end else begin
                bus8.per_frame_vsync = 1'b0;
                bus8.per_frame_href  = 1'b0;
            end
        end
    endtask

    task automatic test_dw10();
        pix10(10'd1023, 10'd1023, 10'd1023, 1'b1, 10'd1023, 10'd512, 10'd512, 1'b0, "d10_white");
        pix10(10'd1023, 10'd0,    10'd0,    1'b1, 10'd308,  10'd340, 10'd1023, 1'b1, "d10_red");
        pix10(10'd1023, 10'd1023, 10'd1023, 1'b0, 10'd0,    10'd0,   10'd0,   1'b0, "d10_href0");
    endtask

    task automatic test_sync_delay();
        @(negedge clk);
        bus10.per_frame_href = 1'b0; bus10.per_frame_hsync = 1'b1; bus10.per_frame_clken = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus10.per_frame_hsync = 1'b0; bus10.per_frame_clken = 1'b1;
            end else if (k == 2) begin
                bus10.per_frame_clken = 1'b0;
            end
            n_checks++;
            if (bus10.post_frame_hsync !== (k == 3))
                $display("FAIL sync hsync k=%0d: got %0b expected %0b", k,
                         bus10.post_frame_hsync, (k == 3));
            else n_pass++;
            n_checks++;
            if (bus10.post_frame_clken !== (k == 4))
                $display("FAIL sync clken k=%0d: got %0b expected %0b", k,
                         bus10.post_frame_clken, (k == 4));
            else n_pass++;
        end
    endtask

    task automatic test_reset_midline();
        // dut8 is in bypass here, so white passes through unchanged.
        pix8(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, "byp_white");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus8.post_img_Y, bus8.post_img_Cb, bus8.post_img_Cr, bus8.post_frame_href} !== 25'd0)
            $display("FAIL midline_reset outputs: got Y=%0d Cb=%0d Cr=%0d href=%0b expected 0",
                     bus8.post_img_Y, bus8.post_img_Cb, bus8.post_img_Cr, bus8.post_frame_href);
        else n_pass++;
        n_checks++;
        if (bus8.mode_active !== 2'd0)
            $display("FAIL midline_reset dut8 mode_active: got %0d expected 0", bus8.mode_active);
        else n_pass++;
        n_checks++;
        if (bus10.mode_active !== 2'd2)
            $display("FAIL midline_reset dut10 mode_active: got %0d expected 2",
                     bus10.mode_active);
        else n_pass++;
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus8.per_frame_href = 1'b1;
        bus8.per_img_red = 8'd100; bus8.per_img_green = 8'd150; bus8.per_img_blue = 8'd200;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus8.per_frame_href = 1'b0;
                bus8.per_img_red = '0; bus8.per_img_green = '0; bus8.per_img_blue = '0;
            end
            n_checks++;
            if ({bus8.post_img_Y, bus8.post_img_Cb, bus8.post_img_Cr} !==
                ((k == 3) ? {8'd141, 8'd161, 8'd99} : 24'd0))
                $display("FAIL post_reset pixel k=%0d: got Y=%0d Cb=%0d Cr=%0d", k,
                         bus8.post_img_Y, bus8.post_img_Cb, bus8.post_img_Cr);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        vsync8(2'd0);
        test_first_vsync();
        test_mode0();
        test_mode1();
        test_mode2();
        test_back_to_back();
        test_dw10();
        test_sync_delay();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
